// File: rtl/sm3_hash_nblk_if.sv
// sm3_hash_nblk_if: request/result bundle for sm3_hash_nblk; SM3_CHAIN_EN adds iv_in/iv_sel
interface sm3_hash_nblk_if #(parameter int MSG_BITS = 640);
  logic start;
  logic abort;
  logic busy;
  logic done;
  logic [MSG_BITS-1:0] msg;
  logic [255:0] hash_out;
`ifdef SM3_CHAIN_EN
  logic [255:0] iv_in;
  logic iv_sel;
  modport master(output start, abort, msg, iv_in, iv_sel, input busy, done, hash_out);
  modport slave(input start, abort, msg, iv_in, iv_sel, output busy, done, hash_out);
`else
  modport master(output start, abort, msg, input busy, done, hash_out);
  modport slave(input start, abort, msg, output busy, done, hash_out);
`endif
endinterface

// File: rtl/sm3_hash_nblk.sv
// sm3_hash_nblk: multi-block SM3 hasher around one sm3_CF core; SM3_CHAIN_EN enables iv_in/iv_sel chaining
module sm3_CF (
  input  logic         clk,
  input  logic         reset,
  input  logic         cf_start,
  input  logic [255:0] iv,
  input  logic [511:0] block,
  output logic [255:0] result,
  output logic         cf_end
);
  function automatic logic [31:0] rol(input logic [31:0] x, input logic [4:0] n);
    return (x << n) | (x >> (6'd32 - {1'b0, n}));
  endfunction
  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rol(x, 5'd9) ^ rol(x, 5'd17);
  endfunction
  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rol(x, 5'd15) ^ rol(x, 5'd23);
  endfunction
  logic start_q, run;
  logic [5:0] j;
  logic [255:0] st, v, nxt;
  logic [511:0] w;
  logic [31:0] a, b, c, d, e, f, g, h, w0, w3, w4, w7, w10, w13;
  logic [31:0] tj, a12, ss1, ss2, ff, gg, tt1, tt2, wnew;
  logic lo;
  assign {a, b, c, d, e, f, g, h} = st;
  assign w0 = w[511:480];
  assign w3 = w[415:384];
  assign w4 = w[383:352];
  assign w7 = w[287:256];
  assign w10 = w[191:160];
  assign w13 = w[95:64];
  always_comb begin
    lo = j < 6'd16;
    tj = lo ? 32'h79cc4519 : 32'h7a879d8a;
    a12 = rol(a, 5'd12);
    ss1 = rol(a12 + e + rol(tj, j[4:0]), 5'd7);
    ss2 = ss1 ^ a12;
    ff = lo ? (a ^ b ^ c) : ((a & b) | (a & c) | (b & c));
    gg = lo ? (e ^ f ^ g) : ((e & f) | (~e & g));
    tt1 = ff + d + ss2 + (w0 ^ w4);
    tt2 = gg + h + ss1 + w0;
    nxt = {tt1, a, rol(b, 5'd9), c, p0(tt2), e, rol(f, 5'd19), g};
    wnew = p1(w0 ^ w7 ^ rol(w13, 5'd15)) ^ rol(w3, 5'd7) ^ w10;
  end
  // a compression begins on a rising cf_start; dropping cf_start cancels it and re-arms
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q <= 1'b0;
      run <= 1'b0;
      j <= '0;
      st <= '0;
      v <= '0;
      w <= '0;
      result <= '0;
      cf_end <= 1'b0;
    end else begin
      start_q <= cf_start;
      cf_end <= 1'b0;
      if (cf_start && !start_q) begin
        st <= iv;
        v <= iv;
        w <= block;
        j <= '0;
        run <= 1'b1;
      end else if (!cf_start) begin
        run <= 1'b0;
      end else if (run) begin
        st <= nxt;
        w <= {w[479:0], wnew};
        j <= j + 6'd1;
        if (j == 6'd63) begin
          run <= 1'b0;
          cf_end <= 1'b1;
          result <= nxt ^ v;
        end
      end
    end
  end
endmodule

module sm3_hash_nblk #(parameter int MSG_BITS = 640) (
  input logic clk,
  input logic reset,
  sm3_hash_nblk_if.slave bus
);
  localparam int NBLK = (MSG_BITS + 65 + 511) / 512;
  localparam int PBITS = NBLK * 512;
  localparam int ZBITS = PBITS - MSG_BITS - 65;
  localparam int CW = $clog2(NBLK + 1);
  localparam logic [255:0] SM3_IV = 256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e;
  typedef enum logic [1:0] {IDLE, RUN, GAP, FIN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic cf_start_q, cf_start_d, done_q, done_d, cf_end;
  logic [255:0] iv_q, iv_d, hash_q, hash_d, cf_result, iv_init;
  logic [MSG_BITS-1:0] msg_q, msg_d;
  logic [PBITS-1:0] pad, pad_sh;
  logic [511:0] blk;
  assign pad = {msg_q, 1'b1, {ZBITS{1'b0}}, 64'(MSG_BITS)};
  assign pad_sh = pad << (32'(cnt_q) * 512);
  assign blk = pad_sh[PBITS-1 -: 512];
`ifdef SM3_CHAIN_EN
  assign iv_init = bus.iv_sel ? bus.iv_in : SM3_IV;
`else
  assign iv_init = SM3_IV;
`endif
  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q;
  assign bus.hash_out = hash_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cf_start_d = cf_start_q;
    iv_d = iv_q;
    hash_d = hash_q;
    msg_d = msg_q;
    done_d = 1'b0;
    if (bus.abort && state_q != IDLE) begin
      state_d = IDLE;
      cf_start_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start && !bus.abort) begin
          state_d = RUN;
          cnt_d = '0;
          cf_start_d = 1'b1;
          iv_d = iv_init;
          msg_d = bus.msg;
        end
        RUN: if (cf_end) begin
          cf_start_d = 1'b0;
          iv_d = cf_result;
          cnt_d = cnt_q + 1'b1;
          state_d = (cnt_d < CW'(NBLK)) ? GAP : FIN;
        end
        GAP: begin
          state_d = RUN;
          cf_start_d = 1'b1;
        end
        FIN: begin
          state_d = IDLE;
          hash_d = iv_q;
          done_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      cf_start_q <= 1'b0;
      done_q <= 1'b0;
      iv_q <= SM3_IV;
      hash_q <= '0;
      msg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cf_start_q <= cf_start_d;
      done_q <= done_d;
      iv_q <= iv_d;
      hash_q <= hash_d;
      msg_q <= msg_d;
    end
  end
  sm3_CF u_cf (
    .clk,
    .reset,
    .cf_start(cf_start_q),
    .iv(iv_q),
    .block(blk),
    .result(cf_result),
    .cf_end
  );
endmodule
